// File: rtl/seg_scan_capture.sv
// Receive side of a scanned seven-segment bus: qualifies each strobed digit, decodes it to a nibble
// and hands complete frames over a valid/ack handshake. Optional macro: SEG_DP_CAPTURE_EN.
module seg_scan_capture #(
    parameter int unsigned NDIGITS       = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             segments,
    input  logic [NDIGITS-1:0]     digit_sel,
    output logic [4*NDIGITS-1:0]   value,
    output logic [NDIGITS-1:0]     err_flags,
    output logic [NDIGITS-1:0]     dp,
    output logic                   frame_valid,
    input  logic                   frame_ack,
    output logic                   overrun
);

    localparam logic [7:0] LP_STABLE = 8'(STABLE_CYCLES);

    // Returns {err, nibble}; unknown glyphs (blank included) decode to 0 with err set.
    function automatic logic [4:0] f_decode(input logic [6:0] seg);
        logic [4:0] res;
        unique case (seg)
            7'h3F: res = 5'h00;
            7'h06: res = 5'h01;
            7'h5B: res = 5'h02;
            7'h4F: res = 5'h03;
            7'h66: res = 5'h04;
            7'h6D: res = 5'h05;
            7'h7D: res = 5'h06;
            7'h07: res = 5'h07;
            7'h7F: res = 5'h08;
            7'h6F: res = 5'h09;
            7'h77: res = 5'h0A;
            7'h7C: res = 5'h0B;
            7'h39: res = 5'h0C;
            7'h5E: res = 5'h0D;
            7'h79: res = 5'h0E;
            7'h71: res = 5'h0F;
            default: res = 5'h10;
        endcase
        return res;
    endfunction

    logic [NDIGITS-1:0]   r_last_sel;
    logic [7:0]           r_last_seg;
    logic [7:0]           r_cnt;
    logic [NDIGITS-1:0]   r_mask;
    logic [4*NDIGITS-1:0] r_wval;
    logic [NDIGITS-1:0]   r_werr;
    logic [4*NDIGITS-1:0] r_value;
    logic [NDIGITS-1:0]   r_err;
    logic                 r_valid;
    logic                 r_overrun;

    logic [7:0]           w_cmp;
    logic                 w_onehot;
    logic                 w_same;
    logic [7:0]           w_cnt_d;
    logic                 w_capture;
    logic                 w_complete;
    logic [NDIGITS-1:0]   w_mask_d;
    logic [4:0]           w_dec;

`ifdef SEG_DP_CAPTURE_EN
    assign w_cmp = segments;
`else
    // The dp line is masked out so toggling it never disturbs the stability count.
    assign w_cmp = {segments[7] & 1'b0, segments[6:0]};
`endif

    always_comb begin
        w_onehot = $onehot(digit_sel);
        w_same   = w_onehot && (digit_sel == r_last_sel) && (w_cmp == r_last_seg);
        w_cnt_d  = 8'd0;
        if (w_onehot) begin
            if (!w_same) begin
                w_cnt_d = 8'd1;
            end else if (r_cnt == LP_STABLE) begin
                w_cnt_d = r_cnt;
            end else begin
                w_cnt_d = r_cnt + 8'd1;
            end
        end
        // Fire only on the transition into the stable count, not while saturated.
        w_capture  = w_onehot && (w_cnt_d == LP_STABLE) && (!w_same || (r_cnt != LP_STABLE));
        w_complete = &r_mask;
        w_mask_d   = (w_complete ? '0 : r_mask) | (w_capture ? digit_sel : '0);
        w_dec      = f_decode(segments[6:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_sel <= '0;
            r_last_seg <= '0;
            r_cnt      <= '0;
            r_mask     <= '0;
            r_wval     <= '0;
            r_werr     <= '0;
        end else begin
            r_cnt  <= w_cnt_d;
            r_mask <= w_mask_d;
            if (!w_onehot) begin
                r_last_sel <= '0;
                r_last_seg <= '0;
            end else if (!w_same) begin
                r_last_sel <= digit_sel;
                r_last_seg <= w_cmp;
            end
            for (int i = 0; i < int'(NDIGITS); i++) begin
                if (w_capture && digit_sel[i]) begin
                    r_wval[4*i +: 4] <= w_dec[3:0];
                    r_werr[i]        <= w_dec[4];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value   <= '0;
            r_err     <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_complete) begin
            if (!r_valid || frame_ack) begin
                r_value <= r_wval;
                r_err   <= r_werr;
                r_valid <= 1'b1;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && frame_ack) begin
            r_valid <= 1'b0;
        end
    end

`ifdef SEG_DP_CAPTURE_EN
    logic [NDIGITS-1:0] r_wdp;
    logic [NDIGITS-1:0] r_dp;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdp <= '0;
            r_dp  <= '0;
        end else begin
            for (int i = 0; i < int'(NDIGITS); i++) begin
                if (w_capture && digit_sel[i]) begin
                    r_wdp[i] <= segments[7];
                end
            end
            if (w_complete && (!r_valid || frame_ack)) begin
                r_dp <= r_wdp;
            end
        end
    end

    assign dp = r_dp;
`else
    assign dp = '0;
`endif

    assign value       = r_value;
    assign err_flags   = r_err;
    assign frame_valid = r_valid;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: a table of whole-frame vectors plus hand-built
// sequences for stability timing, overrun, coincident ack, reset mid-frame and illegal strobes.
module tb_seg_scan_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  segments;
    logic [3:0]  digit_sel;
    logic [15:0] value;
    logic [3:0]  err_flags;
    logic [3:0]  dp;
    logic        frame_valid;
    logic        frame_ack;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    seg_scan_capture #(
        .NDIGITS      (4),
        .STABLE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .segments   (segments),
        .digit_sel  (digit_sel),
        .value      (value),
        .err_flags  (err_flags),
        .dp         (dp),
        .frame_valid(frame_valid),
        .frame_ack  (frame_ack),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] segs;     // byte d is the glyph for digit d
        logic [15:0] exp_val;
        logic [3:0]  exp_err;
        logic [3:0]  exp_dp;
    } frame_vec_t;

    frame_vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic scan_digit(input int d, input logic [7:0] seg, input int hold);
        digit_sel = 4'(1 << d);
        segments  = seg;
        repeat (hold) step();
        digit_sel = 4'b0000;
        step();
    endtask

    task automatic scan_frame(input logic [31:0] segs);
        for (int d = 0; d < 4; d++) scan_digit(d, segs[8*d +: 8], 6);
    endtask

    task automatic do_ack(input string name);
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        chk(name, 32'(frame_valid), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] dp_exp;
`ifdef SEG_DP_CAPTURE_EN
        dp_exp = 4'b1000;
`else
        dp_exp = 4'b0000;
`endif
        vecs[0] = '{segs: 32'h4F5B063F, exp_val: 16'h3210, exp_err: 4'b0000, exp_dp: 4'b0000};
        vecs[1] = '{segs: 32'h077D6D66, exp_val: 16'h7654, exp_err: 4'b0000, exp_dp: 4'b0000};
        vecs[2] = '{segs: 32'h7C776F7F, exp_val: 16'hBA98, exp_err: 4'b0000, exp_dp: 4'b0000};
        vecs[3] = '{segs: 32'h71795E39, exp_val: 16'hFEDC, exp_err: 4'b0000, exp_dp: 4'b0000};
        vecs[4] = '{segs: 32'h4F490600, exp_val: 16'h3010, exp_err: 4'b0101, exp_dp: 4'b0000};
        vecs[5] = '{segs: 32'hE64F5B06, exp_val: 16'h4321, exp_err: 4'b0000, exp_dp: dp_exp};
        vecs[6] = '{segs: 32'h08080808, exp_val: 16'h0000, exp_err: 4'b1111, exp_dp: 4'b0000};

        reset     = 1'b1;
        segments  = 8'h00;
        digit_sel = 4'b0000;
        frame_ack = 1'b0;
        do_reset();
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_err", 32'(err_flags), 32'h0);
        chk("rst_dp", 32'(dp), 32'h0);
        chk("rst_valid", 32'(frame_valid), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);

        // First frame: check the exact cycle frame_valid rises after the last capture.
        scan_digit(0, 8'h06, 6);
        scan_digit(1, 8'h5B, 6);
        scan_digit(2, 8'h4F, 6);
        digit_sel = 4'b1000;
        segments  = 8'h66;
        repeat (4) step();
        chk("t1_valid_early", 32'(frame_valid), 32'd0);
        step();
        chk("t1_valid", 32'(frame_valid), 32'd1);
        chk("t1_value", 32'(value), 32'h4321);
        chk("t1_err", 32'(err_flags), 32'h0);
        digit_sel = 4'b0000;
        step();
        do_ack("t1_ack");

        for (int v = 0; v < 7; v++) begin
            scan_frame(vecs[v].segs);
            chk($sformatf("v%0d_valid", v), 32'(frame_valid), 32'd1);
            chk($sformatf("v%0d_value", v), 32'(value), 32'(vecs[v].exp_val));
            chk($sformatf("v%0d_err", v), 32'(err_flags), 32'(vecs[v].exp_err));
            chk($sformatf("v%0d_dp", v), 32'(dp), 32'(vecs[v].exp_dp));
            chk($sformatf("v%0d_overrun", v), 32'(overrun), 32'd0);
            do_ack($sformatf("v%0d_ack", v));
        end

        // Digit 1 wobbles between 5B and 5E; only a 4-cycle steady 5B may capture it.
        scan_digit(3, 8'h66, 6);
        scan_digit(0, 8'h06, 6);
        scan_digit(2, 8'h4F, 6);
        digit_sel = 4'b0010;
        segments  = 8'h5B;
        repeat (2) step();
        segments = 8'h5E;
        repeat (2) step();
        segments = 8'h5B;
        repeat (3) step();
        chk("stab_3cyc_nocap", 32'(frame_valid), 32'd0);
        step();
        chk("stab_cap_edge", 32'(frame_valid), 32'd0);
        digit_sel = 4'b0000;
        step();
        chk("stab_valid", 32'(frame_valid), 32'd1);
        chk("stab_value", 32'(value), 32'h4321);
        do_ack("stab_ack");

        // Two frames without ack: the first is kept, the second raises overrun.
        scan_frame(32'h065B4F66);
        chk("ovr_first", 32'(value), 32'h1234);
        chk("ovr_not_yet", 32'(overrun), 32'd0);
        scan_frame(32'h6D7D077F);
        chk("ovr_value_held", 32'(value), 32'h1234);
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_valid", 32'(frame_valid), 32'd1);
        do_ack("ovr_ack");
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Ack lands on the same edge that completes the next frame.
        do_reset();
        chk("co_rst_overrun", 32'(overrun), 32'd0);
        scan_frame(32'h664F5B06);
        chk("co_first", 32'(value), 32'h4321);
        scan_digit(0, 8'h66, 6);
        scan_digit(1, 8'h6D, 6);
        scan_digit(2, 8'h7D, 6);
        digit_sel = 4'b1000;
        segments  = 8'h07;
        repeat (4) step();
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        digit_sel = 4'b0000;
        chk("co_valid", 32'(frame_valid), 32'd1);
        chk("co_value", 32'(value), 32'h7654);
        chk("co_overrun", 32'(overrun), 32'd0);
        step();
        chk("co_valid_hold", 32'(frame_valid), 32'd1);
        do_ack("co_ack");

        // Reset after two captures must not leave mask bits or nibbles behind.
        scan_digit(2, 8'h3F, 6);
        scan_digit(3, 8'h3F, 6);
        do_reset();
        scan_digit(0, 8'h5E, 6);
        scan_digit(1, 8'h39, 6);
        chk("mid_rst_no_early", 32'(frame_valid), 32'd0);
        scan_digit(2, 8'h7C, 6);
        scan_digit(3, 8'h77, 6);
        chk("mid_rst_valid", 32'(frame_valid), 32'd1);
        chk("mid_rst_value", 32'(value), 32'hABCD);
        do_ack("mid_rst_ack");

        // Two strobes at once are a blanking condition: nothing may be captured.
        scan_digit(0, 8'h06, 6);
        scan_digit(1, 8'h06, 6);
        scan_digit(2, 8'h06, 6);
        digit_sel = 4'b0011;
        segments  = 8'h66;
        repeat (10) step();
        chk("multi_sel_nocap", 32'(frame_valid), 32'd0);
        digit_sel = 4'b0000;
        step();
        scan_digit(3, 8'h06, 6);
        chk("multi_sel_valid", 32'(frame_valid), 32'd1);
        chk("multi_sel_value", 32'(value), 32'h1111);
        do_ack("multi_sel_ack");

        // Toggling dp alone: with dp ignored it still captures, with dp compared it never settles.
        digit_sel = 4'b0001;
        segments  = 8'h06;
        step();
        segments  = 8'h86;
        step();
        segments  = 8'h06;
        step();
        segments  = 8'h86;
        step();
        digit_sel = 4'b0000;
        step();
        scan_digit(1, 8'h3F, 6);
        scan_digit(2, 8'h3F, 6);
        scan_digit(3, 8'h3F, 6);
`ifdef SEG_DP_CAPTURE_EN
        chk("dp_toggle_valid", 32'(frame_valid), 32'd0);
`else
        chk("dp_toggle_valid", 32'(frame_valid), 32'd1);
        chk("dp_toggle_value", 32'(value), 32'h0001);
        chk("dp_toggle_dp", 32'(dp), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
